cell_updown_counter: RTL and testbench

- Parametrised WIDTH-bit loadable up/down modulo counter, built structurally from the team's logic-cell primitives.
- Datapath: full-adder increment/decrement chain feeding per-bit loadable registers.
- Generalises the single-bit load register into a counting register with synchronous clear, load, direction control, modulo limit and wrap reporting.
- Used as the timebase/index generator for FPGA logic-cell designs (address sequencing, event counting).

---
 rtl/cell_updown_counter.sv | 104 ++++++++++
 tb/tb_cell_updown_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cell_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cell_updown_counter
//  Description : WIDTH-bit loadable up/down modulo counter built from a
//                ripple chain of full-adder cells feeding loadable count
//                registers. Provides synchronous clear, clamped load,
//                direction control, combinational terminal count and a
//                registered one-cycle wrap pulse.
//                Optional macro CNT_SATURATE_EN: counting saturates at the
//                limits instead of wrapping; wrap then pulses on every
//                enabled edge where the count was held at a limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_updown_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_ld_clamped;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;

    // Decrement adds all-ones with no carry-in; increment adds zero with
    // carry-in set. The final carry-out is never formed: limits are detected
    // by comparison, not by adder overflow.
    assign w_addend   = up ? c_ZERO : ~c_ZERO;
    assign w_carry[0] = up;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign w_sum[i] = r_cnt[i] ^ w_addend[i] ^ w_carry[i];
            if (i < WIDTH-1) begin : g_carry
                assign w_carry[i+1] = (r_cnt[i] & w_addend[i]) |
                                      (w_carry[i] & (r_cnt[i] ^ w_addend[i]));
            end
        end
    endgenerate

    // Limit in the current direction: MAX when counting up, 0 when down.
    assign w_at_limit   = up ? (r_cnt == c_MAX) : (r_cnt == c_ZERO);
    assign w_ld_clamped = (ld_val > c_MAX) ? c_MAX : ld_val;

    // Terminal count is suppressed whenever clear or load takes the edge.
    assign tc = en & ~clr & ~ld & w_at_limit;

    // Next-state selection in priority order clear > load > count > hold.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = c_ZERO;
        end else if (ld) begin
            w_cnt_nxt = w_ld_clamped;
        end else if (en) begin
            if (w_at_limit) begin
                w_wrap_nxt = 1'b1;
`ifdef CNT_SATURATE_EN
                w_cnt_nxt  = r_cnt;
`else
                w_cnt_nxt  = up ? c_ZERO : c_MAX;
`endif
            end else begin
                w_cnt_nxt = w_sum;
            end
        end
    end

    // Count and wrap registers; reset acts immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= c_ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_cell_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_updown_counter
//  Description : Self-checking bench for cell_updown_counter. Expected
//                count/wrap values are pushed to a scoreboard when stimulus
//                is driven and popped after the clock edge.
//                With CNT_SATURATE_EN defined the saturating build is
//                exercised at WIDTH=8, MAX=255.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_updown_counter;

`ifdef CNT_SATURATE_EN
    localparam int W = 8;
    localparam int M = 255;
`else
    localparam int W = 4;
    localparam int M = 9;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         ld  = 1'b0;
    logic [W-1:0] ld_val = '0;
    logic         en  = 1'b0;
    logic         up  = 1'b0;
    logic [W-1:0] cnt;
    logic         tc;
    logic         wrap;

    int n_checks = 0;
    int n_pass   = 0;

    int m_cnt = 0;
    int q_cnt[$];
    bit q_wrap[$];

    cell_updown_counter #(.WIDTH(W), .MAX(M)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .ld     (ld),
        .ld_val (ld_val),
        .en     (en),
        .up     (up),
        .cnt    (cnt),
        .tc     (tc),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, required finished)");
        $fatal(1, "timeout");
    end

    // One clock cycle: drive at negedge, check tc, push expectation, then
    // pop and compare after the rising edge.
    task automatic drive_cycle(input bit c, input bit l, input int lv,
                               input bit e, input bit u, input string name);
        bit exp_tc;
        int nxt;
        bit nw;
        int got_c;
        bit got_w;
        @(negedge clk);
        clr = c; ld = l; ld_val = W'(lv); en = e; up = u;
        #1;
        exp_tc = e && !c && !l && ((u && m_cnt == M) || (!u && m_cnt == 0));
        n_checks++;
        if (tc !== exp_tc)
            $display("FAIL %s tc: got %b required %b", name, tc, exp_tc);
        else n_pass++;
        nw = 1'b0;
        if (c) nxt = 0;
        else if (l) nxt = (lv > M) ? M : lv;
        else if (e) begin
            if (u && m_cnt == M) begin
                nw = 1'b1;
`ifdef CNT_SATURATE_EN
                nxt = M;
`else
                nxt = 0;
`endif
            end else if (!u && m_cnt == 0) begin
                nw = 1'b1;
`ifdef CNT_SATURATE_EN
                nxt = 0;
`else
                nxt = M;
`endif
            end else nxt = u ? m_cnt + 1 : m_cnt - 1;
        end else nxt = m_cnt;
        m_cnt = nxt;
        q_cnt.push_back(nxt);
        q_wrap.push_back(nw);
        @(posedge clk);
        #1;
        got_c = q_cnt.pop_front();
        got_w = q_wrap.pop_front();
        n_checks++;
        if (int'(cnt) !== got_c)
            $display("FAIL %s cnt: got %0d required %0d", name, cnt, got_c);
        else n_pass++;
        n_checks++;
        if (wrap !== got_w)
            $display("FAIL %s wrap: got %b required %b", name, wrap, got_w);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cnt !== '0) $display("FAIL reset cnt: got %0d required 0", cnt);
        else n_pass++;
        n_checks++;
        if (wrap !== 1'b0) $display("FAIL reset wrap: got %b required 0", wrap);
        else n_pass++;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL reset tc: got %b required 0", tc);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
    endtask

`ifdef CNT_SATURATE_EN
    task automatic test_saturate();
        drive_cycle(0, 1, 254, 0, 1, "sat_load");
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 1, "sat_up");
        drive_cycle(0, 1, 0, 0, 0, "sat_load0");
        for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 1, 0, "sat_down");
    endtask
`else
    task automatic test_count_up();
        for (int i = 0; i < 12; i++) drive_cycle(0, 0, 0, 1, 1, "count_up");
    endtask

    task automatic test_count_down();
        drive_cycle(1, 0, 0, 1, 1, "clear");
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 0, "count_down");
    endtask

    task automatic test_load_clamp();
        drive_cycle(0, 1, 13, 1, 1, "load_clamp");
        drive_cycle(0, 0, 0, 1, 1, "clamp_wrap");
        drive_cycle(0, 1, 9, 1, 0, "load_max");
        drive_cycle(0, 1, 9, 1, 1, "load_at_max_tc");
    endtask

    task automatic test_clr_ld();
        drive_cycle(0, 1, 7, 0, 0, "load7");
        drive_cycle(1, 1, 3, 1, 1, "clr_over_ld");
        drive_cycle(0, 1, 3, 0, 1, "load3");
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1, "hold");
    endtask

    task automatic test_back_to_back();
        drive_cycle(0, 1, 9, 0, 1, "b2b_load");
        drive_cycle(0, 0, 0, 1, 1, "b2b_wrap_up");
        drive_cycle(0, 0, 0, 1, 0, "b2b_wrap_down");
        drive_cycle(0, 0, 0, 1, 0, "b2b_after");
    endtask

    task automatic test_async_reset();
        drive_cycle(0, 1, 4, 0, 1, "ar_load");
        drive_cycle(0, 0, 0, 1, 1, "ar_to5");
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        n_checks++;
        if (cnt !== '0) $display("FAIL async_reset cnt: got %0d required 0", cnt);
        else n_pass++;
        n_checks++;
        if (wrap !== 1'b0) $display("FAIL async_reset wrap: got %b required 0", wrap);
        else n_pass++;
        #2;
        rst = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 1, "ar_resume");
    endtask
`endif

    initial begin
        test_reset();
`ifdef CNT_SATURATE_EN
        test_saturate();
`else
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_clr_ld();
        test_back_to_back();
        test_async_reset();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
